pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed ID/EX-style pipeline register.
- Carries one generic data bundle and one control bundle between any two pipeline stages.
- Adds a ready/valid handshake with a one-entry skid slot, so a back-pressure stall never drops or duplicates an instruction.
- Supports bubble injection and flush, and keeps a saturating bubble-cycle counter for performance debug.

Parameters:
- DATA_W, 64: width of the data bundle (PC+2, operands, immediates, register addresses).
- CTRL_W, 16: width of the control bundle (ALU function, mem/branch/jump/reg-write flags).
- CTRL_NOP, {CTRL_W{1'b0}}: control value that makes the stage a no-op; driven whenever no valid instruction is presented.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_kill  in  1  qualifies the input: an accepted item has its ctrl replaced by CTRL_NOP (bubble injection, load-use hazard).
- flush  in  1  synchronous squash of all held entries (branch/jump mispredict).
- out_valid  out  1  main slot holds an instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  main slot data.
- out_ctrl  out  CTRL_W  main slot ctrl when out_valid=1, else CTRL_NOP (combinational mux).
- cnt_clr  in  1  synchronous clear of bubble_cnt.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.

Behaviour:
- Storage is a main slot (valid, data, ctrl) and a skid slot (valid, data, ctrl). Occupancy state: EMPTY (0), ONE (1), TWO (2).
- Definitions: acc = in_valid & in_ready; fire = out_valid & out_ready. Stored ctrl = in_kill ? CTRL_NOP : in_ctrl.
- Reset (rst=0, asynchronous):
  - Both valids 0, all data and ctrl registers 0, state EMPTY, bubble_cnt 0.
  - Outputs: out_valid=0, out_ctrl=CTRL_NOP, in_ready=1.
- Latency: 1 cycle, input to out_valid, when not back-pressured. Throughput is 1 per cycle with out_ready held high.
- EMPTY:
  - acc: load main; go to ONE.
  - otherwise: stay in EMPTY.
- ONE:
  - acc & fire: load main with the new item; stay in ONE.
  - acc & !fire: load skid; go to TWO.
  - !acc & fire: go to EMPTY.
  - neither: hold.
- TWO:
  - in_ready=0, so no acceptance.
  - fire: main <= skid, skid_valid <= 0; go to ONE.
  - otherwise: hold both slots.
- Ordering is strictly FIFO; the skid entry is never emitted before the main entry.
- in_ready is a function of registered state only; there is no combinational path from out_ready to in_ready.
- flush=1 (highest priority, synchronous):
  - Next state EMPTY, both valids 0.
  - Any same-cycle acc is discarded.
  - Data registers may keep stale contents; out_ctrl shows CTRL_NOP from the next cycle.
- in_kill: the item still occupies a slot and is counted as valid; only its ctrl becomes CTRL_NOP. in_kill is ignored when acc=0.
- bubble_cnt:
  - Increments by 1 on each clock edge where out_valid=0; saturates at all-ones.
  - cnt_clr has priority: the counter loads 0 and that cycle is not counted.
  - flush does not clear bubble_cnt.
- Reset asserted mid-operation clears everything immediately; on deassertion the stage behaves as if freshly in EMPTY.
- Data/ctrl registers load only when their slot is written. No X-propagation from idle inputs reaches out_ctrl while out_valid=0.

Test Plan:
- Reset with in_valid=1, in_ctrl=16'hFFFF, rst low -> out_valid=0, out_ctrl=16'h0000, in_ready=1, bubble_cnt=0. Release rst -> out_valid=1 one cycle later with ctrl 16'hFFFF.
- Stream items D=1..8, out_ready=1 every cycle -> out_data equals 1..8 on consecutive cycles, 1-cycle latency, in_ready never 0.
- Stream D=1,2,3 with out_ready=0 from the cycle D=1 is valid -> D=2 enters skid, in_ready=0, D=3 held upstream. out_ready=1 -> outputs 1,2,3 in order, no loss or duplicate.
- State TWO (main=A, skid=B) plus flush=1 with in_valid=1, D=C -> next cycle out_valid=0, out_ctrl=CTRL_NOP, in_ready=1. C never appears at the output.
- in_valid=1, in_kill=1, in_ctrl=16'h00A5 -> out_valid=1, out_data passes through, out_ctrl=16'h0000.
- CNT_W=4, idle for 20 cycles -> bubble_cnt saturates at 4'hF. cnt_clr pulse -> 0, then resumes at 1 on the next idle edge.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: one main slot plus one skid slot behind a ready/valid
// handshake, with bubble injection, flush and a saturating bubble-cycle counter.
module pipe_stage_elastic #(
  parameter int unsigned          DATA_W   = 64,
  parameter int unsigned          CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]    CTRL_NOP = {CTRL_W{1'b0}},
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_kill,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [DATA_W-1:0]  main_data_q;
  logic [CTRL_W-1:0]  main_ctrl_q;
  logic [DATA_W-1:0]  skid_data_q;
  logic [CTRL_W-1:0]  skid_ctrl_q;

  logic               skid_valid;
  logic               acc;
  logic               fire;
  logic [CTRL_W-1:0]  store_ctrl;
  logic               load_main_in;
  logic               load_main_skid;
  logic               load_skid;

  // Slot valids are decoded from the registered occupancy, so in_ready never
  // depends combinationally on out_ready.
  assign out_valid  = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);
  assign in_ready   = ~skid_valid;

  assign acc        = in_valid & in_ready;
  assign fire       = out_valid & out_ready;
  assign store_ctrl = in_kill ? CTRL_NOP : in_ctrl;

  assign out_data   = main_data_q;
  assign out_ctrl   = out_valid ? main_ctrl_q : CTRL_NOP;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and slot write enables; flush overrides every transition.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    case (state_q)
      EMPTY: begin
        if (acc) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (acc && fire) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (fire) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Main slot payload: written from the input or promoted from the skid slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (load_main_in) begin
      main_data_q <= in_data;
      main_ctrl_q <= store_ctrl;
    end else if (load_main_skid) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
  end

  // Skid slot payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (load_skid) begin
      skid_data_q <= in_data;
      skid_ctrl_q <= store_ctrl;
    end
  end

  // Bubble counter: clear wins, otherwise count empty-output cycles up to all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: a two-entry FIFO queue model is
// compared with the DUT every cycle, plus directed literal checks.
module tb_pipe_stage_elastic;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_kill;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              cnt_clr;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_elastic #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CTRL_NOP({CTRL_W{1'b0}}),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_kill   (in_kill),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .cnt_clr   (cnt_clr),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } item_t;

  item_t q[$];
  int    mcnt;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stage behaves as a FIFO of capacity two.
  task automatic model_step();
    bit    acc;
    bit    fire;
    item_t it;
    if (!rst) begin
      q.delete();
      mcnt = 0;
      return;
    end
    acc  = in_valid && (q.size() < 2);
    fire = (q.size() > 0) && out_ready;
    if (cnt_clr) mcnt = 0;
    else if (q.size() == 0 && mcnt < 15) mcnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) begin
        it.d = in_data;
        it.c = in_kill ? '0 : in_ctrl;
        q.push_back(it);
      end
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(mcnt));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
    end else begin
      chk("out_ctrl_nop", 64'(out_ctrl), 64'h0);
    end
  endtask

  // One clock: model follows the rising edge, DUT is compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [63:0] d, input logic [15:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    rst = 1'b0;
    in_kill = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    drive(1'b1, 64'h1, 16'hFFFF);
    mcnt = 0;
    cyc(); cyc();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_bubble", 64'(bubble_cnt), 64'h0);
    rst = 1'b1;
    cyc();
    chk("rel_out_valid", 64'(out_valid), 64'h1);
    chk("rel_out_ctrl", 64'(out_ctrl), 64'hFFFF);

    // Full-rate stream.
    drive(1'b0, 64'h0, 16'h0);
    cyc();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 16'(i));
      cyc();
      chk("stream_data", out_data, 64'(i));
      chk("stream_ready", 64'(in_ready), 64'h1);
    end
    drive(1'b0, 64'h0, 16'h0);
    cyc();

    // Back-pressure into the skid slot, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 64'h1, 16'h11); cyc();
    drive(1'b1, 64'h2, 16'h22); cyc();
    chk("skid_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 64'h3, 16'h33); cyc();
    chk("skid_hold_data", out_data, 64'h1);
    out_ready = 1'b1;
    cyc();
    chk("drain2", out_data, 64'h2);
    cyc();
    chk("drain3", out_data, 64'h3);
    drive(1'b0, 64'h0, 16'h0); cyc();
    chk("drain_empty", 64'(out_valid), 64'h0);

    // Flush in TWO discards both entries and the same-cycle input.
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 16'hAA); cyc();
    drive(1'b1, 64'hB, 16'hBB); cyc();
    drive(1'b1, 64'hC, 16'hCC); flush = 1'b1; cyc();
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_ctrl", 64'(out_ctrl), 64'h0);
    chk("flush_ready", 64'(in_ready), 64'h1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 64'h0, 16'h0); cyc();
    chk("flush_no_c", 64'(out_valid), 64'h0);

    // Killed item keeps its slot but carries the no-op ctrl.
    drive(1'b1, 64'h55, 16'h00A5); in_kill = 1'b1; cyc();
    chk("kill_valid", 64'(out_valid), 64'h1);
    chk("kill_data", out_data, 64'h55);
    chk("kill_ctrl", 64'(out_ctrl), 64'h0);
    in_kill = 1'b0;
    drive(1'b0, 64'h0, 16'h0); cyc();

    // Counter saturation and clear.
    for (int i = 0; i < 20; i++) cyc();
    chk("bubble_sat", 64'(bubble_cnt), 64'hF);
    cnt_clr = 1'b1; cyc();
    chk("bubble_clr", 64'(bubble_cnt), 64'h0);
    cnt_clr = 1'b0; cyc();
    chk("bubble_resume", 64'(bubble_cnt), 64'h1);

    // Randomised traffic with occasional flush, kill, clear and reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom(), $urandom()};
      in_ctrl   = 16'($urandom());
      in_kill   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
